// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Groups the processor data-port bus and the transmit byte stream that the
// data_mem_responder serves.
//   MemWrite   : store strobe from the processor
//   Addr       : byte address (processor ALUResult)
//   WriteData  : store data
//   ReadData   : load data, combinational from Addr
//   OUT_Data   : transmit FIFO head byte (0 when empty)
//   OUT_Valid  : transmit FIFO non-empty
//   OUT_Ready  : consumer accepts the head byte
// The master modport is the environment side: the processor plus the byte
// consumer. The slave modport is the responder.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  OUT_Data;
    logic        OUT_Valid;
    logic        OUT_Ready;

    modport master (
        output MemWrite, Addr, WriteData, OUT_Ready,
        input  ReadData, OUT_Data, OUT_Valid
    );

    modport slave (
        input  MemWrite, Addr, WriteData, OUT_Ready,
        output ReadData, OUT_Data, OUT_Valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the processor data port. Each access is decoded
// to a word-addressed data RAM, a 16-byte MMIO window (LED, TXDATA, STATUS,
// CYCLES) or unmapped space. Loads are combinational, stores take effect at
// the rising edge. TXDATA feeds a byte FIFO drained over OUT_Valid/OUT_Ready.
// Ports:
//   CLK   : single clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : slave side of data_mem_responder_if (data bus + transmit stream)
//   LED   : LED register
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0800,
    parameter int unsigned DMEM_WORDS = 128,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0C00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    data_mem_responder_if.slave        bus,
    output logic [7:0]                 LED
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // 33-bit bounds so that a RAM ending at the top of the map cannot wrap.
    localparam logic [32:0] DMEM_LO = {1'b0, DMEM_BASE};
    localparam logic [32:0] DMEM_HI = DMEM_LO + 33'(DMEM_WORDS * 4);

    localparam logic [1:0] OFF_LED  = 2'd0;
    localparam logic [1:0] OFF_TX   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CYC  = 2'd3;

    // ---------------- state ----------------
    logic [31:0]   ram_q [DMEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    led_q,    led_d;
    logic [31:0]   cyc_q,    cyc_d;
    logic          ovf_q,    ovf_d;
    logic [CW-1:0] count_q,  count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // ---------------- decode ----------------
    logic [32:0]   addr_ext_s;
    logic [32:0]   dmem_off_s;
    logic          dmem_hit_s;
    logic [AW-1:0] dmem_idx_s;
    logic          mmio_hit_s;
    logic [1:0]    mmio_off_s;
    logic          unused_s;

    assign addr_ext_s = {1'b0, bus.Addr};
    assign dmem_off_s = addr_ext_s - DMEM_LO;
    // DMEM_BASE is word aligned, so comparing the full byte address gives the
    // same result as comparing the word address.
    assign dmem_hit_s = (addr_ext_s >= DMEM_LO) && (addr_ext_s < DMEM_HI);
    assign dmem_idx_s = dmem_off_s[AW+1:2];
    assign mmio_hit_s = (bus.Addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off_s = bus.Addr[3:2];
    assign unused_s   = ^{dmem_off_s[32:AW+2], dmem_off_s[1:0]};

    // ---------------- strobes ----------------
    logic full_s, empty_s;
    logic ram_we_s, wr_led_s, wr_stat_s, wr_cyc_s;
    logic push_req_s, push_ok_s, pop_s;

    assign full_s    = (count_q == CW'(FIFO_DEPTH));
    assign empty_s   = (count_q == CW'(0));
    assign ram_we_s  = bus.MemWrite && dmem_hit_s && !RESET;
    assign wr_led_s  = bus.MemWrite && mmio_hit_s && (mmio_off_s == OFF_LED);
    assign wr_stat_s = bus.MemWrite && mmio_hit_s && (mmio_off_s == OFF_STAT);
    assign wr_cyc_s  = bus.MemWrite && mmio_hit_s && (mmio_off_s == OFF_CYC);
    assign push_req_s = bus.MemWrite && mmio_hit_s && (mmio_off_s == OFF_TX) && !RESET;
    assign pop_s      = !empty_s && bus.OUT_Ready && !RESET;
    // A full FIFO still takes a push when the head leaves in the same edge.
    assign push_ok_s  = push_req_s && (!full_s || pop_s);

    // ---------------- outputs ----------------
    assign bus.OUT_Valid = !empty_s;
    assign bus.OUT_Data  = empty_s ? 8'h00 : fifo_q[rd_ptr_q];
    assign LED           = led_q;

    // Combinational load path: selects RAM word or MMIO register for Addr.
    always_comb begin
        bus.ReadData = 32'h0000_0000;
        if (dmem_hit_s) begin
            bus.ReadData = ram_q[dmem_idx_s];
        end else if (mmio_hit_s) begin
            case (mmio_off_s)
                OFF_LED:  bus.ReadData = {24'h00_0000, led_q};
                OFF_TX:   bus.ReadData = 32'h0000_0000;
                OFF_STAT: bus.ReadData = {16'h0000, 8'(count_q), 5'b00000,
                                          ovf_q, empty_s, full_s};
                OFF_CYC:  bus.ReadData = cyc_q;
                default:  bus.ReadData = 32'h0000_0000;
            endcase
        end else begin
            bus.ReadData = 32'h0000_0000;
        end
    end

    // Next-state logic for LED, cycle counter, overflow flag and FIFO control.
    always_comb begin
        led_d    = led_q;
        cyc_d    = cyc_q + 32'd1;
        ovf_d    = ovf_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (wr_led_s) begin
            led_d = bus.WriteData[7:0];
        end else begin
            led_d = led_q;
        end

        if (wr_cyc_s) begin
            cyc_d = 32'h0000_0000;
        end else begin
            cyc_d = cyc_q + 32'd1;
        end

        // A dropped push sets overflow even if the same write clears it.
        if (push_req_s && !push_ok_s) begin
            ovf_d = 1'b1;
        end else if (wr_stat_s && bus.WriteData[2]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q    <= 8'h00;
            cyc_q    <= 32'h0000_0000;
            ovf_q    <= 1'b0;
            count_q  <= CW'(0);
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
        end else begin
            led_q    <= led_d;
            cyc_q    <= cyc_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO byte storage; stale entries are masked by the empty flag.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            ram_q[dmem_idx_s] <= bus.WriteData;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed stimulus with a scoreboard: each check queues its expected value
// and kind; a negedge monitor pops and compares. Transmitted bytes are queued
// when pushed and compared by the monitor on every OUT_Valid && OUT_Ready.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic       clk;
    logic       rst;
    logic [7:0] led;

    data_mem_responder_if bus ();

    data_mem_responder dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave),
        .LED   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_RD    = 0;
    localparam int K_LED   = 1;
    localparam int K_VALID = 2;
    localparam int K_ODATA = 3;

    int          compared   = 0;
    int          mismatched = 0;
    logic        chk_en     = 1'b0;
    int          exp_kind_q [$];
    logic [31:0] exp_val_q  [$];
    string       exp_name_q [$];
    logic [7:0]  exp_byte_q [$];

    int          m_kind;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;
    logic [7:0]  m_byte;

    // Monitor: compares queued checks and every accepted stream byte.
    always @(negedge clk) begin
        if (chk_en) begin
            compared++;
            if (exp_val_q.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard: check strobe with nothing queued");
            end else begin
                m_kind = exp_kind_q.pop_front();
                m_exp  = exp_val_q.pop_front();
                m_name = exp_name_q.pop_front();
                case (m_kind)
                    K_RD:    m_act = bus.ReadData;
                    K_LED:   m_act = {24'h0, led};
                    K_VALID: m_act = {31'h0, bus.OUT_Valid};
                    default: m_act = {24'h0, bus.OUT_Data};
                endcase
                if (m_act !== m_exp) begin
                    mismatched++;
                    $display("FAIL %s: got %08h expected %08h", m_name, m_act, m_exp);
                end
            end
        end
        if (bus.OUT_Valid === 1'b1 && bus.OUT_Ready === 1'b1 && rst === 1'b0) begin
            compared++;
            if (exp_byte_q.size() == 0) begin
                mismatched++;
                $display("FAIL stream: unexpected byte %02h", bus.OUT_Data);
            end else begin
                m_byte = exp_byte_q.pop_front();
                if (bus.OUT_Data !== m_byte) begin
                    mismatched++;
                    $display("FAIL stream: got %02h expected %02h", bus.OUT_Data, m_byte);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.Addr      = a;
        bus.WriteData = d;
        cyc();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [31:0] a, input logic [31:0] e, input string nm);
        bus.Addr = a;
        exp_kind_q.push_back(kind);
        exp_val_q.push_back(e);
        exp_name_q.push_back(nm);
        chk_en = 1'b1;
        cyc();
        chk_en = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        wr(32'h0000_0C04, {24'h0, b});
        if (accepted) exp_byte_q.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.OUT_Ready = 1'b1;
        while (bus.OUT_Valid === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        bus.OUT_Ready = 1'b0;
        compared++;
        if (bus.OUT_Valid !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_timeout: OUT_Valid %b after %0d cycles, required 0", bus.OUT_Valid, n);
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'h0;
        bus.WriteData = 32'h0;
        bus.OUT_Ready = 1'b0;
        rst           = 1'b1;
        #1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        chk(K_LED,   32'h0,         32'h0, "reset_led");
        chk(K_VALID, 32'h0,         32'h0, "reset_valid");
        chk(K_ODATA, 32'h0,         32'h0, "reset_odata");
        chk(K_RD,    32'h0000_0C08, 32'h0000_0002, "reset_status");

        // Data RAM and unmapped space
        wr(32'h0000_0800, 32'hDEAD_BEEF);
        wr(32'h0000_09FC, 32'h1234_5678);
        chk(K_RD, 32'h0000_0800, 32'hDEAD_BEEF, "ram_first");
        chk(K_RD, 32'h0000_09FC, 32'h1234_5678, "ram_last");
        chk(K_RD, 32'h0000_0803, 32'hDEAD_BEEF, "ram_lowbits");
        chk(K_RD, 32'h0000_0A00, 32'h0, "unmapped_above");
        chk(K_RD, 32'h0000_07FC, 32'h0, "unmapped_below");

        // LED register
        wr(32'h0000_0C00, 32'h0000_01A5);
        chk(K_LED, 32'h0,         32'h0000_00A5, "led_out");
        chk(K_RD,  32'h0000_0C00, 32'h0000_00A5, "led_read");

        // Fill past full with consumer stalled
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b0);
        chk(K_RD, 32'h0000_0C08, 32'h0000_0405, "status_full_ovf");
        chk(K_RD, 32'h0000_0C04, 32'h0, "txdata_read");
        drain();
        chk(K_VALID, 32'h0,         32'h0,         "drained_valid");
        chk(K_RD,    32'h0000_0C08, 32'h0000_0006, "status_empty_ovf");
        wr(32'h0000_0C08, 32'h0000_0004);
        chk(K_RD,    32'h0000_0C08, 32'h0000_0002, "status_ovf_cleared");

        // Push into a full FIFO while the head is being popped
        push_byte(8'hA1, 1'b1);
        push_byte(8'hA2, 1'b1);
        push_byte(8'hA3, 1'b1);
        push_byte(8'hA4, 1'b1);
        bus.OUT_Ready = 1'b1;
        push_byte(8'h66, 1'b1);
        bus.OUT_Ready = 1'b0;
        chk(K_RD, 32'h0000_0C08, 32'h0000_0401, "status_push_pop_full");
        drain();

        // Cycle counter clear, increment and wrap
        wr(32'h0000_0C0C, 32'h0);
        chk(K_RD, 32'h0000_0C0C, 32'h0000_0000, "cycles_zero");
        chk(K_RD, 32'h0000_0C0C, 32'h0000_0001, "cycles_one");
        dut.cyc_q = 32'hFFFF_FFFE;
        chk(K_RD, 32'h0000_0C0C, 32'hFFFF_FFFE, "cycles_preset");
        chk(K_RD, 32'h0000_0C0C, 32'hFFFF_FFFF, "cycles_max");
        chk(K_RD, 32'h0000_0C0C, 32'h0000_0000, "cycles_wrap");

        // Reset mid-operation; a write during reset is ignored
        wr(32'h0000_0C00, 32'h0000_005A);
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b0);
        chk(K_LED,   32'h0, 32'h0000_005A, "pre_reset_led");
        chk(K_VALID, 32'h0, 32'h1,         "pre_reset_valid");
        rst = 1'b1;
        wr(32'h0000_0C00, 32'h0000_00FF);
        rst = 1'b0;
        chk(K_VALID, 32'h0,         32'h0,         "post_reset_valid");
        chk(K_LED,   32'h0,         32'h0,         "post_reset_led");
        chk(K_RD,    32'h0000_0C08, 32'h0000_0002, "post_reset_status");
        chk(K_RD,    32'h0000_0800, 32'hDEAD_BEEF, "post_reset_ram");

        cyc();
        compared++;
        if (exp_byte_q.size() != 0 || exp_val_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftovers: %0d bytes and %0d checks still queued, required 0",
                     exp_byte_q.size(), exp_val_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data port. It sits on the other end of the `MemWrite` / `ALUResult` / `WriteData` / `ReadData` interface and serves that port in the same cycle. It decodes each address into one of three targets: a word-addressed data RAM, a small memory-mapped I/O window, or unmapped space. The I/O window holds an LED register, a free-running cycle counter, and a byte transmit FIFO that drains to an external consumer over a valid/ready handshake.

## Interface
Parameters:
- `DMEM_BASE`, default 32'h0000_0800: byte base address of the data RAM.
- `DMEM_WORDS`, default 128: RAM depth in 32-bit words; must be a power of two.
- `MMIO_BASE`, default 32'h0000_0C00: base of the 16-byte I/O window; must be 16-byte aligned.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; must be a power of two, 2..16.

Ports:
- `CLK`  in  1: the block's single clock. All state updates on its rising edge.
- `RESET`  in  1: reset, synchronous and active-high.
- `MemWrite`  in  1: write strobe from the processor.
- `Addr`  in  32: byte address, driven by the processor's ALUResult.
- `WriteData`  in  32: store data.
- `ReadData`  out  32: load data, combinational from `Addr`.
- `LED`  out  8: LED register.
- `OUT_Data`  out  8: FIFO head byte; reads 0 when the FIFO is empty.
- `OUT_Valid`  out  1: FIFO non-empty.
- `OUT_Ready`  in  1: the consumer accepts the head byte.

## Operation
- Address decode ignores `Addr[1:0]`; all accesses are full-word.
- DMEM hit: `DMEM_BASE <= Addr < DMEM_BASE + 4*DMEM_WORDS`. The word index is `(Addr - DMEM_BASE) >> 2`.
- MMIO hit: `Addr[31:4] == MMIO_BASE[31:4]`. The register offset is `Addr[3:2]`.
- Unmapped addresses read 0. Writes to them are ignored.
- RAM read is combinational. RAM write happens at the rising edge when `MemWrite` is high. RAM contents are not reset.
- MMIO register map:
  - Offset 0x0, LED: read/write. Reads return {24'b0, LED}. A write loads `WriteData[7:0]`.
  - Offset 0x4, TXDATA: write pushes `WriteData[7:0]`. Reads return 0.
  - Offset 0x8, STATUS: read returns [0] full, [1] empty, [2] overflow, [15:8] count, all other bits 0. Writing with `WriteData[2]=1` clears overflow. Other written bits are ignored.
  - Offset 0xC, CYCLES: read returns the 32-bit counter. Any write zeroes it.
- FIFO push:
  - A push to TXDATA while full is dropped, and the sticky overflow bit is set.
  - Exception: a push in the same cycle as a pop (`OUT_Valid && OUT_Ready`) is accepted even when full. Count stays at `FIFO_DEPTH`.
- FIFO pop: occurs when `OUT_Valid && OUT_Ready` at the edge. Head order is strict FIFO. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Push and pop in the same cycle on a non-empty, non-full FIFO: count is unchanged.
- Push into an empty FIFO: the byte appears on `OUT_Data` the cycle after the push edge. There is no same-cycle bypass.
- Overflow set and clear in the same cycle: set wins.
- Cycle counter: increments by 1 each cycle and wraps from 32'hFFFF_FFFF to 0. A CYCLES write has priority over the increment.

## Timing
- Reset values, one edge after `RESET` is sampled high:
  - `LED` = 0; FIFO empty with count 0; `OUT_Valid` = 0; `OUT_Data` = 0; overflow = 0; counter = 0.
- While `RESET` is high:
  - All writes are ignored and the counter holds at 0.
  - Handshakes are ignored, so no pop is counted.
  - Reset mid-operation discards all FIFO contents.
- Load latency is 0 cycles: `ReadData` reflects current state and current `Addr` in the same cycle.
- Store latency is 1 edge. A read of the same address in the cycle after the write returns the new value.
- `OUT_Valid` and `OUT_Data` are registered-state outputs and change only at clock edges.
- Consumer rule: `OUT_Data` is held stable while `OUT_Valid` is high and `OUT_Ready` is low.
- CYCLES: reading in the cycle after a CYCLES write returns 0. Reading the cycle after that returns 1.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x800 and 32'h12345678 to 0x9FC. Read both back → exact values. A read of 0xA00 → 0; a read of 0x7FC → 0.
- Write 32'h1A5 to 0xC00 → `LED` = 8'hA5 on the next cycle; a read of 0xC00 → 32'h0000_00A5.
- With `OUT_Ready` = 0, push 0x11, 0x22, 0x33, 0x44, 0x55 to 0xC04:
  - STATUS = 32'h0000_0405 (count 4, full, overflow).
  - Raise `OUT_Ready` → `OUT_Data` sequence is 11, 22, 33, 44; then `OUT_Valid` = 0 and STATUS = 32'h0000_0006.
  - Write 4 to 0xC08 → STATUS = 32'h0000_0002.
- FIFO full with `OUT_Ready` = 1: push 0x66 → accepted; count stays 4; overflow stays 0; 0x66 emerges fifth.
- Write 0 to 0xC0C → reads of 0xC0C on the next two cycles return 0 and then 1. Force the counter near 32'hFFFF_FFFF (hierarchical deposit) → it wraps to 0.
- Assert `RESET` for 1 cycle with 3 bytes queued and `LED` = 8'h5A → `OUT_Valid` = 0, `LED` = 0, STATUS = 32'h0000_0002, and a RAM word written earlier is still intact.
